// File: rtl/dmem_if.sv
// Core <-> data-memory request/response bundle. Both channels are valid/ready:
// a beat transfers on a rising clk edge where valid and ready are both high.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// RV32 data-memory responder: one outstanding load/store, fixed LATENCY from
// request accept to rsp_valid, byte-lane writes and funct3 load extension.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          exec, use_live;
  logic          op_we;
  logic [2:0]    op_f3;
  logic [31:0]   op_addr, op_wdata;
  logic [1:0]    lane;
  logic [AW-1:0] op_idx;
  logic          op_err;
  logic [31:0]   rd_word, ld_val, wdata_al;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    be, mem_be;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    exec     = 1'b0;
    use_live = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = LAT_M1;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            // Single-cycle memory executes on the accept edge from the live inputs.
            state_d  = RESP;
            exec     = 1'b1;
            use_live = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          exec    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    op_we    = use_live ? bus.req_we     : we_q;
    op_f3    = use_live ? bus.req_funct3 : f3_q;
    op_addr  = use_live ? bus.req_addr   : addr_q;
    op_wdata = use_live ? bus.req_wdata  : wdata_q;
    lane     = op_addr[1:0];
    op_idx   = op_addr[AW+1:2];

    op_err = (op_f3 == 3'b011) || (op_f3 == 3'b110) || (op_f3 == 3'b111) ||
             ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
             ((op_f3 == 3'b010) && (lane != 2'b00)) ||
             ({1'b0, op_addr} >= ADDR_LIMIT);

    rd_word = op_err ? 32'd0 : mem[op_idx];
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      3'b010:  ld_val = rd_word;
      default: ld_val = 32'd0;
    endcase

    case (op_f3[1:0])
      2'b00:   begin be = 4'b0001 << lane; wdata_al = {4{op_wdata[7:0]}}; end
      2'b01:   begin be = op_addr[1] ? 4'b1100 : 4'b0011; wdata_al = {2{op_wdata[15:0]}}; end
      default: begin be = 4'b1111; wdata_al = op_wdata; end
    endcase

    mem_be = (exec && op_we && !op_err && !reset) ? be : 4'b0000;

    if (exec) begin
      err_d   = op_err;
      rdata_d = (op_we || op_err) ? 32'd0 : ld_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; only per-byte enables gate the write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) mem[op_idx][8*b +: 8] <= wdata_al[8*b +: 8];
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions
// plus hand-written backpressure and mid-transaction reset sequences.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  dmem_if     bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];
  int   n_vec;
  int   n_bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vt.push_back(v);
  endtask

  // Drive one request, scramble the request fields after accept, wait for rsp_valid.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.rsp_valid && lat < 40);
  endtask

  task automatic complete(input string nm);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({nm, " idle_after_rsp"}, {30'd0, bus.req_ready, bus.rsp_valid}, 32'b10);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    issue(v.we, v.f3, v.addr, v.wdata, lat);
    check({nm, " latency"}, 32'(lat), 32'(LAT));
    check({nm, " rdata"}, bus.rsp_rdata, v.exp_rd);
    check({nm, " err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    complete(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    logic [31:0] held;
    n_vec = 0;
    n_bad = 0;

    add(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    add(0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0);
    add(0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0);
    add(0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0);
    add(1, 3'b000, 32'h11,  32'h000000AA, 32'h0,        0);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 0);
    add(1, 3'b001, 32'h12,  32'h00001234, 32'h0,        0);
    add(0, 3'b010, 32'h10,  32'h0,        32'h1234AAEF, 0);
    add(0, 3'b010, 32'h12,  32'h0,        32'h0,        1);
    add(1, 3'b001, 32'h11,  32'h0000FFFF, 32'h0,        1);
    add(0, 3'b010, 32'h10,  32'h0,        32'h1234AAEF, 0);
    add(0, 3'b011, 32'h10,  32'h0,        32'h0,        1);
    add(0, 3'b010, 32'h400, 32'h0,        32'h0,        1);
    add(1, 3'b000, 32'h3FF, 32'h0000005A, 32'h0,        0);
    add(0, 3'b100, 32'h3FF, 32'h0,        32'h0000005A, 0);
    add(0, 3'b000, 32'h3FF, 32'h0,        32'h0000005A, 0);
    add(0, 3'b001, 32'h11,  32'h0,        32'h0,        1);
    add(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFAA, 0);
    add(0, 3'b101, 32'h10,  32'h0,        32'h0000AAEF, 0);
    add(1, 3'b010, 32'h20,  32'h11223344, 32'h0,        0);
    add(0, 3'b010, 32'h20,  32'h0,        32'h11223344, 0);

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    check("reset state",     {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Backpressure: response held 5 cycles, a stray request must be ignored.
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat);
    check("bp latency", 32'(lat), 32'(LAT));
    held = bus.rsp_rdata;
    check("bp rdata", held, 32'h1234AAEF);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h0;
      end else begin
        bus.req_valid  = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("bp hold%0d valid", c), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("bp hold%0d rdata", c), bus.rsp_rdata, 32'h1234AAEF);
      check($sformatf("bp hold%0d req_ready", c), {31'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    complete("bp");
    v.we = 0; v.f3 = 3'b010; v.addr = 32'h10; v.wdata = 0; v.exp_rd = 32'h1234AAEF; v.exp_err = 0;
    run_vec("bp reread", v);

    // Reset one cycle after accepting a store: no response, no write.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h55;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    check("abort busy", {30'd0, dbg_state}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      check("abort no rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    v.we = 0; v.f3 = 3'b010; v.addr = 32'h20; v.wdata = 0; v.exp_rd = 32'h11223344; v.exp_err = 0;
    run_vec("abort reread", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
